// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and constants for the sequential multiplier
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Step counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_add_w.sv
// rtl/mult_add_w.sv - WIDTH-bit ripple-carry adder used as the multiplier datapath
module mult_add_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  output logic [WIDTH-1:0] s,
  output logic             Cout
);

  logic [WIDTH:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign Cout = c[WIDTH];

endmodule

// File: rtl/seq_mult8.sv
// rtl/seq_mult8.sv - shift-and-add unsigned multiplier with valid/ready on both sides
// Optional SEQ_MULT8_ZERO_SKIP_EN: zero operands complete one edge after accept.
module seq_mult8
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P
);

  localparam int CW = cnt_width(WIDTH);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_s;
  logic                 add_c;
  logic [2*WIDTH-1:0]   step_prod;
  logic                 zero_op;

  assign add_b = prod_q[0] ? mcand_q : '0;

  mult_add_w #(.WIDTH(WIDTH)) u_add (
    .a    (prod_q[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .Cin  (1'b0),
    .s    (add_s),
    .Cout (add_c)
  );

  // Carry re-enters at the MSB so no product bit is ever dropped.
  assign step_prod = {add_c, add_s, prod_q[WIDTH-1:1]};

`ifdef SEQ_MULT8_ZERO_SKIP_EN
  assign zero_op = (A == '0) || (B == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = A;
          // A zero operand runs a single step on a cleared product.
          prod_d  = zero_op ? '0 : {{WIDTH{1'b0}}, B};
          cnt_d   = zero_op ? CW'(WIDTH - 1) : '0;
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d = step_prod;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          p_d     = step_prod;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign P         = p_q;

endmodule
